// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of a simple in-order pipeline. Holds the program
//   counter, presents it to a combinational instruction memory, and captures
//   the returned word into the IF/ID pipeline register.
//
// Ports
//   clk            rising-edge clock for all state
//   rst            asynchronous active-low reset
//   stall          hold the PC and the IF/ID register
//   flush          turn the instruction being captured into a bubble
//   branch_taken   redirect the PC to branch_target (also bubbles IF/ID)
//   branch_target  redirect address (low two bits ignored)
//   imem_addr      read address to the instruction memory (the PC itself)
//   imem_data      instruction word for imem_addr, same cycle
//   if_pc          PC of the instruction held in IF/ID
//   if_pc_plus4    if_pc + 4
//   if_instr       instruction held in IF/ID (NOP when a bubble)
//   if_valid       IF/ID holds a real instruction
//   fetch_count    number of valid captures since reset (wraps at 2^32)

module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_plus4,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_valid,
  output logic [31:0]           fetch_count
);

  // addi x0, x0, 0 -- the canonical RISC-V NOP used to fill bubbles
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  kill;

  // The memory address is the PC register itself, so stall/flush/branch
  // never reach imem_addr through combinational logic.
  assign imem_addr = pc;

  // Natural overflow of the adder gives the required wrap to zero.
  assign pc_plus4 = pc + ADDR_WIDTH'(4);

  // A redirect always discards whatever was fetched this cycle.
  assign kill = flush | branch_taken;

  // Next-PC selection: redirect beats stall beats sequential. The target is
  // forced word-aligned so the PC can never become misaligned.
  always_comb begin
    pc_next = pc_plus4;
    if (branch_taken) begin
      pc_next = {branch_target[ADDR_WIDTH-1:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID register. A bubble only clears valid and the instruction; the PC
  // fields keep their last values so downstream debug still sees them.
  // fetch_count tracks real captures only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= NOP;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (kill) begin
      if_instr    <= NOP;
      if_valid    <= 1'b0;
    end else if (!stall) begin
      if_pc       <= pc;
      if_pc_plus4 <= pc_plus4;
      if_instr    <= imem_data;
      if_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: three fixed words, everything else is addr ^ DEAD0000
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; flush = 0; branch_taken = 0; branch_target = '0;
    #1 rst = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_addr: got %h want %h", imem_addr, 32'h0); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", if_valid); end
    total++; if (if_instr !== 32'h13) begin bad++; $display("[TB] FAIL rst_instr: got %h want %h", if_instr, 32'h13); end
    total++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL rst_pcs: got %h/%h want 0/0", if_pc, if_pc_plus4); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL rst_count: got %0d want 0", fetch_count); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    total++; if (if_instr !== 32'h11 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h4 || if_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_edge1: got %h pc %h pc4 %h v %b want 11 0 4 1", if_instr, if_pc, if_pc_plus4, if_valid); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL seq_addr1: got %h want 4", imem_addr); end
    step();
    total++; if (if_instr !== 32'h22 || if_pc !== 32'h4) begin bad++; $display("[TB] FAIL seq_edge2: got %h pc %h want 22 4", if_instr, if_pc); end
    step();
    total++; if (if_instr !== 32'h33 || if_pc !== 32'h8 || if_pc_plus4 !== 32'hC) begin bad++; $display("[TB] FAIL seq_edge3: got %h pc %h pc4 %h want 33 8 c", if_instr, if_pc, if_pc_plus4); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("[TB] FAIL seq_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    total++; if (imem_addr !== 32'h8 || fetch_count !== 32'd2) begin bad++; $display("[TB] FAIL stall_setup: got addr %h cnt %0d want 8 2", imem_addr, fetch_count); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_addr%0d: got %h want 8", i, imem_addr); end
      total++; if (if_instr !== 32'h22 || if_pc !== 32'h4 || if_pc_plus4 !== 32'h8 || if_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold%0d: got %h pc %h pc4 %h v %b want 22 4 8 1", i, if_instr, if_pc, if_pc_plus4, if_valid); end
      total++; if (fetch_count !== 32'd2) begin bad++; $display("[TB] FAIL stall_count%0d: got %0d want 2", i, fetch_count); end
    end
    stall = 1'b0;
    step();
    total++; if (if_instr !== 32'h33 || if_pc !== 32'h8 || fetch_count !== 32'd3 || imem_addr !== 32'hC) begin bad++; $display("[TB] FAIL stall_resume: got %h pc %h cnt %0d addr %h want 33 8 3 c", if_instr, if_pc, fetch_count, imem_addr); end
  endtask

  task automatic test_branch();
    step();
    total++; if (imem_addr !== 32'h10 || if_instr !== 32'hDEAD_000C || fetch_count !== 32'd4) begin bad++; $display("[TB] FAIL br_setup: got addr %h instr %h cnt %0d want 10 dead000c 4", imem_addr, if_instr, fetch_count); end
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL br_addr: got %h want 100", imem_addr); end
    total++; if (if_valid !== 1'b0 || if_instr !== 32'h13) begin bad++; $display("[TB] FAIL br_bubble: got v %b instr %h want 0 13", if_valid, if_instr); end
    total++; if (if_pc !== 32'hC || if_pc_plus4 !== 32'h10 || fetch_count !== 32'd4) begin bad++; $display("[TB] FAIL br_keep: got pc %h pc4 %h cnt %0d want c 10 4", if_pc, if_pc_plus4, fetch_count); end
    step();
    total++; if (if_instr !== 32'hDEAD_0100 || if_pc !== 32'h100 || if_valid !== 1'b1 || fetch_count !== 32'd5) begin bad++; $display("[TB] FAIL br_target: got %h pc %h v %b cnt %0d want dead0100 100 1 5", if_instr, if_pc, if_valid, fetch_count); end
  endtask

  task automatic test_simultaneous();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    total++; if (imem_addr !== 32'h40 || if_valid !== 1'b0 || if_instr !== 32'h13) begin bad++; $display("[TB] FAIL sim_stall_br: got addr %h v %b instr %h want 40 0 13", imem_addr, if_valid, if_instr); end
    branch_taken = 1'b0; stall = 1'b0;
    step();
    total++; if (if_instr !== 32'hDEAD_0040 || fetch_count !== 32'd6 || imem_addr !== 32'h44) begin bad++; $display("[TB] FAIL sim_capture: got %h cnt %0d addr %h want dead0040 6 44", if_instr, fetch_count, imem_addr); end
    stall = 1'b1; flush = 1'b1;
    step();
    total++; if (imem_addr !== 32'h44) begin bad++; $display("[TB] FAIL sim_stall_flush_addr: got %h want 44", imem_addr); end
    total++; if (if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h40 || fetch_count !== 32'd6) begin bad++; $display("[TB] FAIL sim_stall_flush_if: got v %b instr %h pc %h cnt %0d want 0 13 40 6", if_valid, if_instr, if_pc, fetch_count); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_align: got %h want fffffffc", imem_addr); end
    step();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc: got %h want 0", imem_addr); end
    total++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instr !== 32'h2152_FFFC || fetch_count !== 32'd7) begin bad++; $display("[TB] FAIL wrap_if: got pc %h pc4 %h instr %h cnt %0d want fffffffc 0 2152fffc 7", if_pc, if_pc_plus4, if_instr, fetch_count); end
  endtask

  task automatic test_midrun_reset();
    step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    #2 rst = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h13) begin bad++; $display("[TB] FAIL mid_rst_a: got addr %h v %b instr %h want 0 0 13", imem_addr, if_valid, if_instr); end
    total++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 || fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_b: got pc %h pc4 %h cnt %0d want 0 0 0", if_pc, if_pc_plus4, fetch_count); end
    step();
    total++; if (imem_addr !== 32'h0 || fetch_count !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_hold: got addr %h cnt %0d want 0 0", imem_addr, fetch_count); end
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    total++; if (if_instr !== 32'h11 || if_pc !== 32'h0 || if_valid !== 1'b1 || fetch_count !== 32'd1 || imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL mid_rst_release: got %h pc %h v %b cnt %0d addr %h want 11 0 1 1 4", if_instr, if_pc, if_valid, fetch_count, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_simultaneous();
    test_wrap();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL provide parameter ADDR_WIDTH, default 32, meaning the PC and instruction-memory address width.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 stall  input  1  hazard stall: hold the PC and the IF/ID register.
REQ-008 flush  input  1  kill the instruction being captured into IF/ID.
REQ-009 branch_taken  input  1  redirect the PC to branch_target.
REQ-010 branch_target  input  ADDR_WIDTH  redirect address.
REQ-011 imem_addr  output  ADDR_WIDTH  read address to the combinational instruction memory.
REQ-012 imem_data  input  DATA_WIDTH  instruction word returned by the instruction memory in the same cycle.
REQ-013 if_pc  output  ADDR_WIDTH  IF/ID registered PC of the instruction held in IF/ID.
REQ-014 if_pc_plus4  output  ADDR_WIDTH  IF/ID registered if_pc + 4.
REQ-015 if_instr  output  DATA_WIDTH  IF/ID registered instruction.
REQ-016 if_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-017 fetch_count  output  32  number of instructions captured as valid since reset.

Function
REQ-018 imem_addr SHALL equal the PC register combinationally, with zero added latency.
REQ-019 Next-PC priority per rising edge SHALL be: branch_taken -> {branch_target[ADDR_WIDTH-1:2], 2'b00}; else stall -> PC held; else PC + 4.
REQ-020 PC + 4 SHALL wrap modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-021 The low two bits of branch_target SHALL be ignored, and the PC SHALL always stay word-aligned.
REQ-022 IF/ID update priority per edge SHALL be: (flush | branch_taken) -> bubble; else stall -> hold all IF/ID fields; else capture {PC, PC+4, imem_data} with if_valid = 1.
REQ-023 A bubble SHALL set if_valid = 0 and if_instr = 32'h0000_0013 (NOP), and SHALL leave if_pc and if_pc_plus4 at their previous values.
REQ-024 When stall and branch_taken are both asserted, the redirect SHALL win: PC <- target and IF/ID <- bubble.
REQ-025 When stall and flush are both asserted without branch_taken, the PC SHALL hold and IF/ID SHALL become a bubble.
REQ-026 Instruction latency SHALL be one cycle: the word at PC P appears on if_instr on the edge after imem_addr = P, provided there is no stall or flush.
REQ-027 fetch_count SHALL increment by 1 on each edge where IF/ID captures with if_valid = 1, and SHALL wrap at 2^32.
REQ-028 The block SHALL contain no combinational path from the stall, flush or branch inputs to imem_addr.

Reset
REQ-029 While rst = 0, the block SHALL immediately force: PC = RESET_PC, if_valid = 0, if_instr = 32'h0000_0013, if_pc = 0, if_pc_plus4 = 0, fetch_count = 0.
REQ-030 On the first rising edge after rst is released, the block SHALL capture the instruction at RESET_PC, giving if_valid = 1 and PC = RESET_PC + 4.
REQ-031 Asserting rst mid-operation, including during a stall or redirect, SHALL override all other inputs asynchronously.

Verification
REQ-032 Sequential fetch: release reset with RESET_PC = 0 and memory words 0x11, 0x22, 0x33 -> if_instr shows 0x11, 0x22, 0x33 on edges 1–3, if_pc shows 0, 4, 8, and fetch_count = 3.
REQ-033 Stall: assert stall for 2 cycles at PC = 8 -> imem_addr stays 8, all IF/ID fields hold, fetch_count is unchanged, and fetch resumes at 8 after stall drops.
REQ-034 Branch: branch_taken = 1 with branch_target = 0x103 at PC = 0x10 -> next PC = 0x100, if_valid = 0 and if_instr = 0x13 for one cycle, then the word at 0x100 is captured.
REQ-035 Simultaneous events: stall = 1 and branch_taken = 1 with target 0x40 -> PC = 0x40 and a bubble; stall = 1 and flush = 1 -> PC held and a bubble.
REQ-036 Wrap-around: force PC to 0xFFFF_FFFC via a branch -> the next PC is 0x0000_0000 and if_pc_plus4 = 0x0000_0000.
REQ-037 Mid-run reset: drive rst low between clock edges -> outputs take their reset values before the next edge, and after release the first capture is at RESET_PC.
